// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a TDM stream; gathers one beat per slot and publishes whole frames.
// Ports:
//    clk        sole clock
//    rst_n      asynchronous active-low reset
//    in_valid   beat present this cycle
//    in_sof     beat is slot 0 of a new frame (qualified by in_valid)
//    in_data    channel word for the current slot
//    out_data   last complete frame, channel k at [k*WIDTH +: WIDTH]
//    out_valid  one-cycle pulse when out_data takes a new frame
//    ch_sel     slot the next non-SOF beat will fill (0 when idle)
//    busy       frame partially received
//    frame_err  one-cycle pulse on a premature SOF
module tdm_demux #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [WIDTH-1:0]          in_data,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      out_valid,
   output logic [$clog2(CHANNELS)-1:0] ch_sel,
   output logic                      busy,
   output logic                      frame_err
);
   localparam int CW = $clog2(CHANNELS);
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
   typedef enum logic {IDLE, RECV} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, wr_idx;
   logic wr, pub, err;
   logic [(CHANNELS-1)*WIDTH-1:0] stage;
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr        = 1'b0;
      wr_idx    = cnt;
      pub       = 1'b0;
      err       = 1'b0;
      if (in_valid) begin
         if (in_sof) begin
            // an SOF always restarts the frame; mid-frame it also flags an error
            state_nxt = RECV;
            cnt_nxt   = CW'(1);
            wr        = 1'b1;
            wr_idx    = '0;
            err       = state == RECV;
         end else if (state == RECV) begin
            if (cnt == LAST) begin
               pub       = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               wr      = 1'b1;
               cnt_nxt = cnt + CW'(1);
            end
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         stage     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         out_valid <= pub;
         frame_err <= err;
         if (wr) stage[wr_idx*WIDTH +: WIDTH] <= in_data;
         // the last word goes straight to the output, bypassing staging
         if (pub) out_data <= {in_data, stage};
      end
   end
   assign ch_sel = cnt;
   assign busy   = state == RECV;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: table-driven, hand-sequenced and randomized checks of tdm_demux against a frame-level model.
module tb_tdm_demux;
   localparam int CH = 4;
   localparam int W  = 8;
   localparam int SW = $clog2(CH);
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, in_sof = 1'b0;
   logic [W-1:0] in_data = '0;
   logic [CH*W-1:0] out_data;
   logic out_valid, busy, frame_err;
   logic [SW-1:0] ch_sel;
   int vectors = 0, miscompares = 0;
   tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_data(out_data), .out_valid(out_valid), .ch_sel(ch_sel), .busy(busy), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   // frame-level model: collect words of the current frame in a queue
   logic [W-1:0] words[$];
   bit in_frame = 0;
   logic [CH*W-1:0] m_data = '0;
   logic m_valid = 0, m_busy = 0, m_err = 0;
   logic [SW-1:0] m_sel = '0;
   task automatic model_reset();
      words.delete();
      in_frame = 0;
      m_data = '0; m_valid = 0; m_busy = 0; m_err = 0; m_sel = '0;
   endtask
   task automatic model(input logic v, input logic s, input logic [W-1:0] d);
      m_valid = 0;
      m_err = 0;
      if (v) begin
         if (s) begin
            m_err = in_frame;
            words.delete();
            words.push_back(d);
            in_frame = 1;
         end else if (in_frame) begin
            words.push_back(d);
            if (words.size() == CH) begin
               for (int k = 0; k < CH; k++) m_data[k*W +: W] = words[k];
               m_valid = 1;
               words.delete();
               in_frame = 0;
            end
         end
      end
      m_sel = in_frame ? SW'(words.size()) : '0;
      m_busy = in_frame;
   endtask
   task automatic step(input logic v, input logic s, input logic [W-1:0] d);
      in_valid = v;
      in_sof = s;
      in_data = d;
      @(posedge clk);
      #1;
      model(v, s, d);
   endtask
   task automatic check(input string name, input logic [CH*W-1:0] ed, input logic ev,
                        input logic [SW-1:0] es, input logic eb, input logic ee);
      vectors++;
      if (out_data !== ed || out_valid !== ev || ch_sel !== es || busy !== eb || frame_err !== ee) begin
         miscompares++;
         $display("FAIL %s: got data=%h valid=%b sel=%0d busy=%b err=%b, want data=%h valid=%b sel=%0d busy=%b err=%b",
                  name, out_data, out_valid, ch_sel, busy, frame_err, ed, ev, es, eb, ee);
      end
   endtask
   task automatic check_model(input string name);
      check(name, m_data, m_valid, m_sel, m_busy, m_err);
   endtask
   typedef struct {
      logic v, s;
      logic [W-1:0] d;
      logic [CH*W-1:0] ed;
      logic ev;
      logic [SW-1:0] es;
      logic eb, ee;
   } vec_t;
   vec_t tv[19];
   initial begin
      tv[0]  = '{1, 1, 8'h11, 32'h0, 0, 1, 1, 0};
      tv[1]  = '{1, 0, 8'h22, 32'h0, 0, 2, 1, 0};
      tv[2]  = '{1, 0, 8'h33, 32'h0, 0, 3, 1, 0};
      tv[3]  = '{1, 0, 8'h44, 32'h44332211, 1, 0, 0, 0};
      tv[4]  = '{1, 1, 8'hAA, 32'h44332211, 0, 1, 1, 0};
      tv[5]  = '{1, 0, 8'hBB, 32'h44332211, 0, 2, 1, 0};
      tv[6]  = '{1, 1, 8'h01, 32'h44332211, 0, 1, 1, 1};
      tv[7]  = '{1, 0, 8'h02, 32'h44332211, 0, 2, 1, 0};
      tv[8]  = '{1, 0, 8'h03, 32'h44332211, 0, 3, 1, 0};
      tv[9]  = '{1, 0, 8'h04, 32'h04030201, 1, 0, 0, 0};
      tv[10] = '{1, 0, 8'h55, 32'h04030201, 0, 0, 0, 0};
      tv[11] = '{1, 1, 8'h0A, 32'h04030201, 0, 1, 1, 0};
      tv[12] = '{1, 0, 8'h0B, 32'h04030201, 0, 2, 1, 0};
      tv[13] = '{1, 0, 8'h0C, 32'h04030201, 0, 3, 1, 0};
      tv[14] = '{1, 0, 8'h0D, 32'h0D0C0B0A, 1, 0, 0, 0};
      tv[15] = '{1, 1, 8'h1A, 32'h0D0C0B0A, 0, 1, 1, 0};
      tv[16] = '{1, 0, 8'h1B, 32'h0D0C0B0A, 0, 2, 1, 0};
      tv[17] = '{1, 0, 8'h1C, 32'h0D0C0B0A, 0, 3, 1, 0};
      tv[18] = '{1, 0, 8'h1D, 32'h1D1C1B1A, 1, 0, 0, 0};
      model_reset();
      // reset held with inputs toggling
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'($urandom);
         in_sof = 1'($urandom);
         in_data = W'($urandom);
         @(posedge clk);
         #1;
         check("reset_hold", '0, 0, '0, 0, 0);
      end
      in_valid = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      check("reset_release", '0, 0, '0, 0, 0);
      // nominal, premature SOF, junk in idle, back-to-back
      for (int i = 0; i < 19; i++) begin
         step(tv[i].v, tv[i].s, tv[i].d);
         check($sformatf("table_%0d", i), tv[i].ed, tv[i].ev, tv[i].es, tv[i].eb, tv[i].ee);
      end
      step(0, 0, 8'h00);
      check("b2b_valid_drop", 32'h1D1C1B1A, 0, 0, 0, 0);
      // gaps of 3 idle cycles between beats
      for (int b = 0; b < CH; b++) begin
         step(1, b == 0, W'(8'h11 * (b + 1)));
         check_model($sformatf("gap_beat_%0d", b));
         for (int g = 0; g < 3; g++) begin
            step(0, $urandom_range(0, 1) == 1, W'($urandom));
            check_model($sformatf("gap_idle_%0d_%0d", b, g));
         end
      end
      check("gap_result", 32'h44332211, 0, 0, 0, 0);
      // mid-frame reset
      step(1, 1, 8'h11);
      check_model("mr_sof");
      step(1, 0, 8'h22);
      check_model("mr_slot1");
      #2 rst_n = 0;
      #1;
      model_reset();
      check("mr_async_clear", '0, 0, '0, 0, 0);
      @(negedge clk);
      rst_n = 1;
      step(1, 0, 8'h33);
      check("mr_no_sof_1", '0, 0, '0, 0, 0);
      step(1, 0, 8'h44);
      check("mr_no_sof_2", '0, 0, '0, 0, 0);
      step(0, 0, 8'h00);
      check_model("mr_after");
      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, W'($urandom));
         check_model($sformatf("rand_%0d", i));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a serial TDM channel stream produced by a TDM multiplexer.
- Accepts one WIDTH-bit beat per valid cycle. A start-of-frame flag marks channel 0.
- Distributes each beat into its channel slot. Publishes a complete frame of CHANNELS words in parallel, with a one-cycle valid pulse.
- Sits between the serial link datapath and per-channel consumers.

Parameters:
- CHANNELS, 4, number of TDM slots per frame (legal range 2..16).
- WIDTH, 8, bits per channel word.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat on in_data/in_sof is valid this cycle.
- in_sof  input  1  qualified by in_valid; this beat is slot 0 of a new frame.
- in_data  input  WIDTH  channel word for the current slot.
- out_data  output  CHANNELS*WIDTH  last complete frame; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle pulse: out_data just updated with a new frame.
- ch_sel  output  $clog2(CHANNELS)  slot index the next accepted non-SOF beat will fill; 0 in IDLE.
- busy  output  1  high while in RECV (frame partially received).
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Ports are clk and rst_n.
  - rst_n low immediately clears all state: out_data=0, out_valid=0, ch_sel=0, busy=0, frame_err=0, staging registers=0, state=IDLE.
- State machine has two states, IDLE and RECV.
  - Slot counter cnt is $clog2(CHANNELS) bits. ch_sel=cnt.
- Staging registers: CHANNELS-1 words, holding slots 0..CHANNELS-2.
- Beat accepted only when in_valid=1. in_valid=0 is a gap: no state change, cnt held, gaps of any length allowed mid-frame.
- IDLE:
  - Accepted beat with in_sof=1: store to slot 0, cnt<=1, go RECV.
  - Accepted beat with in_sof=0: discarded, no error, stay IDLE.
- RECV, accepted beat with in_sof=0:
  - If cnt<CHANNELS-1: store to slot cnt, cnt<=cnt+1.
  - If cnt==CHANNELS-1 (last slot):
    - On the same edge, out_data<=staged slots 0..CHANNELS-2 plus in_data as slot CHANNELS-1. The final word bypasses staging.
    - out_valid<=1 for exactly the next cycle. cnt<=0, go IDLE.
    - Latency: out_valid is high in the cycle immediately after the last beat is accepted, coincident with the new out_data.
- RECV, accepted beat with in_sof=1 (premature SOF):
  - frame_err<=1 for one cycle. Partial frame is discarded; out_data unchanged, no out_valid.
  - The beat is taken as slot 0 of a new frame: cnt<=1, stay RECV.
- out_data holds its value between frames. Partial frames never alter out_data.
- Back-to-back frames:
  - The SOF of frame N+1 may arrive the cycle after frame N's last beat. It is accepted normally from IDLE.
  - out_valid for frame N and acceptance of slot 0 of frame N+1 occur in the same cycle.
- No backpressure: the block always accepts.
- Reset asserted mid-frame aborts the frame with no out_valid and no frame_err. After deassertion, the block needs an SOF.

Test Plan (CHANNELS=4, WIDTH=8):
1. Reset: hold rst_n=0 with random inputs toggling -> all outputs 0. Release -> ch_sel=0, busy=0.
2. Nominal frame: beats {sof,0x11},0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44, out_valid=1 and out_data=0x44332211. ch_sel sequence 0,1,2,3,0.
3. Gaps: same frame with 3 idle cycles between each beat -> identical out_data 0x44332211, single out_valid pulse, busy high from cycle after SOF to the last beat.
4. Premature SOF: {sof,0xAA},0xBB, then {sof,0x01},0x02,0x03,0x04 -> frame_err pulse after the second SOF; out_data=0x04030201 with one out_valid; 0xAA/0xBB never appear.
5. Junk in IDLE and back-to-back: 0x55 without SOF, then two consecutive frames 0x0D0C0B0A and 0x1D1C1B1A with no gap -> 0x55 ignored; two out_valid pulses, 4 cycles apart, with correct values.
6. Mid-frame reset: {sof,0x11},0x22, then rst_n pulse, then 0x33,0x44 without SOF -> out_data stays 0, no out_valid, no frame_err.
